// File: rtl/mem_port_arbiter_if.sv
// Request/response bundle shared by the fetch port, the data port and the memory port.
// The slave modport is the arbiter's view; master is the environment around it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ready_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_ready_o;
  logic [DATA_W-1:0] dm_rdata_o;

  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i;
  logic [DATA_W-1:0] mem_rdata_i;

  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_ready_o, if_rdata_o,
    input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    output dm_ready_o, dm_rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  mem_ack_i, mem_rdata_i,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_ready_o, if_rdata_o,
    output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
    input  dm_ready_o, dm_rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output mem_ack_i, mem_rdata_i,
    input  busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the data stage.
// Data wins ties; a saturating streak counter hands fetch a turn after MAX_STREAK data grants.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  mem_port_arbiter_if.slave   bus
);
  localparam int              SW         = $clog2(MAX_STREAK + 1);
  localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_STREAK);

  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

  typedef struct packed {
    logic              ready;
    logic [DATA_W-1:0] rdata;
  } port_rsp_t;

  state_t    state_q, state_d;
  mem_cmd_t  cmd_q, cmd_d;
  port_rsp_t if_q, if_d, dm_q, dm_d;
  logic [SW-1:0] streak_q, streak_d;
  logic      busy_q, busy_d;
  logic      arb, ir, dr, gnt_i, gnt_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      if_q     <= '0;
      dm_q     <= '0;
      streak_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      if_q     <= if_d;
      dm_q     <= dm_d;
      streak_q <= streak_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    if_d        = if_q;
    if_d.ready  = 1'b0;
    dm_d        = dm_q;
    dm_d.ready  = 1'b0;
    streak_d    = streak_q;

    // The port just served may still hold its request in its RESP cycle, so mask it.
    arb   = (state_q == IDLE) || (state_q == RESP_I) || (state_q == RESP_D);
    ir    = bus.if_req_i && (state_q != RESP_I);
    dr    = bus.dm_req_i && (state_q != RESP_D);
    gnt_d = arb && dr && !(ir && (streak_q == STREAK_MAX));
    gnt_i = arb && ir && !gnt_d;

    case (state_q)
      BUSY_I: begin
        if (bus.mem_ack_i) begin
          if_d.rdata = bus.mem_rdata_i;
          if_d.ready = 1'b1;
          cmd_d.req  = 1'b0;
          cmd_d.we   = 1'b0;
          state_d    = RESP_I;
        end
      end
      BUSY_D: begin
        if (bus.mem_ack_i) begin
          if (!cmd_q.we) dm_d.rdata = bus.mem_rdata_i;
          dm_d.ready = 1'b1;
          cmd_d.req  = 1'b0;
          cmd_d.we   = 1'b0;
          state_d    = RESP_D;
        end
      end
      default: begin
        state_d = IDLE;
        if (gnt_d) begin
          state_d = BUSY_D;
          cmd_d   = '{req: 1'b1, we: bus.dm_we_i, addr: bus.dm_addr_i, wdata: bus.dm_wdata_i};
          if (!bus.if_req_i)               streak_d = '0;
          else if (streak_q != STREAK_MAX) streak_d = streak_q + SW'(1);
        end else if (gnt_i) begin
          state_d  = BUSY_I;
          cmd_d    = '{req: 1'b1, we: 1'b0, addr: bus.if_addr_i, wdata: DATA_W'(0)};
          streak_d = '0;
        end
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.mem_req_o   = cmd_q.req;
  assign bus.mem_we_o    = cmd_q.we;
  assign bus.mem_addr_o  = cmd_q.addr;
  assign bus.mem_wdata_o = cmd_q.wdata;
  assign bus.if_ready_o  = if_q.ready;
  assign bus.if_rdata_o  = if_q.rdata;
  assign bus.dm_ready_o  = dm_q.ready;
  assign bus.dm_rdata_o  = dm_q.rdata;
  assign bus.busy_o      = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a small word memory answers requests after a
// programmable number of wait cycles; every step compares outputs against hand-derived values.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: acks after wait_cyc extra cycles of a held request, reads/writes on ack.
  logic [31:0] mem [0:63] = '{4: 32'h8C020004, default: 32'h0};
  logic        model_en    = 1'b1;
  int          wait_cyc    = 0;
  int          wcnt        = 0;
  logic        model_ack   = 1'b0;
  logic [31:0] model_rdata = 32'h0;
  logic        force_ack   = 1'b0;
  logic [31:0] force_rdata = 32'h0;

  assign bus.mem_ack_i   = model_ack | force_ack;
  assign bus.mem_rdata_i = force_ack ? force_rdata : model_rdata;

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (model_en && bus.mem_req_o) begin
      if (wcnt == wait_cyc) begin
        model_ack   = 1'b1;
        model_rdata = mem[bus.mem_addr_o[7:2]];
        if (bus.mem_we_o) mem[bus.mem_addr_o[7:2]] = bus.mem_wdata_o;
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.if_req_i   = 1'b0;
    bus.if_addr_i  = '0;
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_addr_i  = '0;
    bus.dm_wdata_i = '0;

    // Reset state
    step(2);
    check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    check("rst_busy",    32'(bus.busy_o),    32'd0);
    check("rst_if_rdy",  32'(bus.if_ready_o), 32'd0);
    check("rst_dm_rdy",  32'(bus.dm_ready_o), 32'd0);
    check("rst_addr",    bus.mem_addr_o,      32'h0);
    rst = 1'b0;
    step(1);

    // Single fetch, zero-wait memory
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    step(1);
    check("f_mem_req_c1", 32'(bus.mem_req_o), 32'd1);
    check("f_addr_c1",    bus.mem_addr_o,     32'h10);
    check("f_we_c1",      32'(bus.mem_we_o),  32'd0);
    check("f_busy_c1",    32'(bus.busy_o),    32'd1);
    step(1);
    check("f_if_rdy_c2",  32'(bus.if_ready_o), 32'd1);
    check("f_if_rdata",   bus.if_rdata_o,      32'h8C020004);
    check("f_dm_rdy_c2",  32'(bus.dm_ready_o), 32'd0);
    check("f_mem_req_c2", 32'(bus.mem_req_o),  32'd0);
    bus.if_req_i = 1'b0;
    step(1);
    check("f_if_rdy_c3",  32'(bus.if_ready_o), 32'd0);
    check("f_busy_c3",    32'(bus.busy_o),     32'd0);

    // Data write then read-back
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h08;
    bus.dm_wdata_i = 32'h2A;
    step(1);
    check("w_mem_we",    32'(bus.mem_we_o), 32'd1);
    check("w_mem_wdata", bus.mem_wdata_o,   32'h2A);
    check("w_mem_addr",  bus.mem_addr_o,    32'h08);
    step(1);
    check("w_dm_rdy",    32'(bus.dm_ready_o), 32'd1);
    check("w_dm_rdata",  bus.dm_rdata_o,      32'h0);
    check("w_we_drop",   32'(bus.mem_we_o),   32'd0);
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_wdata_i = 32'h0;
    step(1);
    bus.dm_req_i = 1'b1;
    step(1);
    check("r_mem_we",    32'(bus.mem_we_o), 32'd0);
    step(1);
    check("r_dm_rdy",    32'(bus.dm_ready_o), 32'd1);
    check("r_dm_rdata",  bus.dm_rdata_o,      32'h2A);
    bus.dm_req_i = 1'b0;
    step(1);

    // Wait states: ack arrives in the sixth cycle of the request
    wait_cyc       = 5;
    bus.dm_req_i   = 1'b1;
    bus.dm_we_i    = 1'b1;
    bus.dm_addr_i  = 32'h20;
    bus.dm_wdata_i = 32'h55;
    for (int i = 1; i <= 5; i++) begin
      step(1);
      check($sformatf("ws_addr_%0d", i),  bus.mem_addr_o,      32'h20);
      check($sformatf("ws_we_%0d", i),    32'(bus.mem_we_o),   32'd1);
      check($sformatf("ws_wdata_%0d", i), bus.mem_wdata_o,     32'h55);
      check($sformatf("ws_busy_%0d", i),  32'(bus.busy_o),     32'd1);
      check($sformatf("ws_rdy_%0d", i),   32'(bus.dm_ready_o), 32'd0);
    end
    step(1);
    check("ws_rdy_ack_cyc", 32'(bus.dm_ready_o), 32'd0);
    step(1);
    check("ws_rdy_pulse",   32'(bus.dm_ready_o), 32'd1);
    bus.dm_req_i   = 1'b0;
    bus.dm_we_i    = 1'b0;
    bus.dm_wdata_i = 32'h0;
    step(1);
    check("ws_rdy_after",   32'(bus.dm_ready_o), 32'd0);
    wait_cyc = 0;

    // Reset while BUSY_D, then a stray ack
    model_en      = 1'b0;
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h08;
    step(1);
    check("rm_busy_pre", 32'(bus.busy_o), 32'd1);
    rst          = 1'b1;
    bus.dm_req_i = 1'b0;
    step(1);
    check("rm_mem_req",  32'(bus.mem_req_o), 32'd0);
    check("rm_mem_addr", bus.mem_addr_o,     32'h0);
    check("rm_busy",     32'(bus.busy_o),    32'd0);
    check("rm_dm_rdata", bus.dm_rdata_o,     32'h0);
    check("rm_if_rdata", bus.if_rdata_o,     32'h0);
    rst = 1'b0;
    step(1);
    force_ack   = 1'b1;
    force_rdata = 32'hDEADBEEF;
    step(1);
    check("stray_dm_rdy", 32'(bus.dm_ready_o), 32'd0);
    check("stray_if_rdy", 32'(bus.if_ready_o), 32'd0);
    check("stray_busy",   32'(bus.busy_o),     32'd0);
    force_ack = 1'b0;
    step(1);
    check("stray_dm_rdata", bus.dm_rdata_o, 32'h0);
    check("stray_if_rdata", bus.if_rdata_o, 32'h0);
    model_en = 1'b1;

    // Alternation: data first, fetch granted straight out of RESP_D
    bus.if_req_i  = 1'b1;
    bus.if_addr_i = 32'h10;
    bus.dm_req_i  = 1'b1;
    bus.dm_addr_i = 32'h08;
    step(1);
    check("alt_d_addr", bus.mem_addr_o, 32'h08);
    step(1);
    check("alt_d_rdy",   32'(bus.dm_ready_o), 32'd1);
    check("alt_d_rdata", bus.dm_rdata_o,      32'h2A);
    bus.dm_req_i = 1'b0;
    step(1);
    check("alt_i_req",  32'(bus.mem_req_o), 32'd1);
    check("alt_i_addr", bus.mem_addr_o,     32'h10);
    step(1);
    check("alt_i_rdy",   32'(bus.if_ready_o), 32'd1);
    check("alt_i_rdata", bus.if_rdata_o,      32'h8C020004);
    bus.if_req_i = 1'b0;
    step(1);

    // Anti-starvation: fetch withdraws only in each RESP_D, so every grant starts from IDLE
    bus.if_req_i = 1'b1;
    bus.dm_req_i = 1'b1;
    for (int r = 0; r < 4; r++) begin
      step(1);
      check($sformatf("st_d%0d_addr", r), bus.mem_addr_o,      32'h08);
      step(1);
      check($sformatf("st_d%0d_rdy", r),  32'(bus.dm_ready_o), 32'd1);
      bus.if_req_i = 1'b0;
      step(1);
      check($sformatf("st_d%0d_idle", r), 32'(bus.busy_o),     32'd0);
      bus.if_req_i = 1'b1;
    end
    step(1);
    check("st_i_addr",  bus.mem_addr_o,     32'h10);
    check("st_i_we",    32'(bus.mem_we_o),  32'd0);
    step(1);
    check("st_i_rdy",   32'(bus.if_ready_o), 32'd1);
    bus.if_req_i = 1'b0;
    step(1);
    check("st_d_resume_req",  32'(bus.mem_req_o), 32'd1);
    check("st_d_resume_addr", bus.mem_addr_o,     32'h08);
    step(1);
    check("st_d_resume_rdy",  32'(bus.dm_ready_o), 32'd1);
    bus.dm_req_i = 1'b0;
    step(1);
    check("st_end_busy", 32'(bus.busy_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
